// File: rtl/aff7s_pkg.sv
// Shared constants and helpers for the aff7s 7-segment scan driver.
// Latency: n/a (package). Backpressure: n/a.
// Segment codes are seg[6:0] = g..a, active-low.
package aff7s_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aff7s_tick.sv
// Slot prescaler and blink-phase frame counter for the scan driver.
// Latency: slot_end/dead are combinational from the prescaler; blink_phase is registered.
// Backpressure: none, free-running.
module aff7s_tick
    import aff7s_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD_CYC  = 16,
    parameter int BLINK_DIV = 128
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_end,
    output logic slot_end,
    output logic dead,
    output logic blink_phase
);

    localparam int PW = idx_w(SCAN_DIV);
    localparam int FW = idx_w(BLINK_DIV);

    logic [PW-1:0] psc;
    logic [FW-1:0] fcnt;

    assign slot_end = (psc == PW'(SCAN_DIV - 1));
    assign dead     = (psc < PW'(DEAD_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
        end else if (slot_end) begin
            psc <= '0;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    // Phase flips once every BLINK_DIV completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aff7s_scan.sv
// Time-multiplexed N-digit hex driver for common-anode 7-segment banks.
// Latency: one clk from scan state to pins; new loads show from the next slot boundary.
// Backpressure: none; load is always accepted, display never stalls.
module aff7s_scan
    import aff7s_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD_CYC  = 16,
    parameter int BLINK_DIV = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an
);

    localparam int IW = idx_w(N_DIGITS);

    logic [4*N_DIGITS-1:0] val_pend, val_sh;
    logic [N_DIGITS-1:0]   dp_pend, dp_sh;
    logic [IW-1:0]         idx;
    logic                  idx_last, slot_end, frame_end, dead, blink_phase;
    logic [N_DIGITS-1:0]   lz_blank, an_sel, an_n;
    logic                  lead, cur_dp, cur_dark, dp_n;
    logic [3:0]            cur_hex;
    logic [6:0]            seg_n;

    assign idx_last  = (idx == IW'(N_DIGITS - 1));
    assign frame_end = slot_end & idx_last;

    aff7s_tick #(
        .SCAN_DIV  (SCAN_DIV),
        .DEAD_CYC  (DEAD_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_end   (frame_end),
        .slot_end    (slot_end),
        .dead        (dead),
        .blink_phase (blink_phase)
    );

    // Two-stage shadow: loads land in pend, the displayed copy only moves on a slot boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_pend <= '0;
            dp_pend  <= '0;
            val_sh   <= '0;
            dp_sh    <= '0;
        end else begin
            if (load) begin
                val_pend <= value;
                dp_pend  <= dp_in;
            end
            if (slot_end) begin
                val_sh <= val_pend;
                dp_sh  <= dp_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= idx_last ? '0 : idx + 1'b1;
        end
    end

    // Walk from the MSB; a non-zero digit or a lit dp ends the leading run.
    always_comb begin
        lead     = blank_lz;
        lz_blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lead        = lead && (val_sh[4*i +: 4] == 4'h0) && !dp_sh[i];
            lz_blank[i] = (i > 0) ? lead : 1'b0;
        end
    end

    always_comb begin
        cur_hex  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_sel   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_hex   = val_sh[4*i +: 4];
                cur_dp    = dp_sh[i];
                cur_dark  = lz_blank[i] | (blink_mask[i] & blink_phase);
                an_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        seg_n = SEG_OFF;
        dp_n  = 1'b1;
        an_n  = '1;
        if (enable && !dead) begin
            an_n  = an_sel;
            seg_n = cur_dark ? SEG_OFF : hex2seg(cur_hex);
            dp_n  = ~(cur_dp & ~cur_dark);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_n;
            dp  <= dp_n;
            an  <= an_n;
        end
    end

endmodule

// File: tb/tb_aff7s_scan.sv
// Directed bench for aff7s_scan with a short scan slot (8 clk, 2 dead) and fast blink.
module tb_aff7s_scan;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 2;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic          load;
    logic          enable;
    logic          blank_lz;
    logic [3:0]    dp_in;
    logic [3:0]    blink_mask;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;

    int checks   = 0;
    int failures = 0;

    aff7s_scan #(
        .N_DIGITS  (N),
        .SCAN_DIV  (SD),
        .DEAD_CYC  (DC),
        .BLINK_DIV (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_an(input logic [3:0] exp, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an === exp) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF) begin
            failures++;
            $display("FAIL reset_state: seg=%h dp=%b an=%b want 7f 1 1111", seg, dp, an);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (an !== 4'hF) break;
        end
        checks++;
        if (cnt !== DC + 1 || an !== 4'b1110 || seg !== 7'h40) begin
            failures++;
            $display("FAIL reset_first_active: clk=%0d an=%b seg=%h want %0d 1110 40", cnt, an, seg, DC + 1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF) begin
            failures++;
            $display("FAIL reset_mid_slot: seg=%h dp=%b an=%b want 7f 1 1111", seg, dp, an);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (an !== 4'hF) break;
        end
        checks++;
        if (cnt !== DC + 1 || an !== 4'b1110) begin
            failures++;
            $display("FAIL reset_restart: clk=%0d an=%b want %0d 1110", cnt, an, DC + 1);
        end
    endtask

    task automatic test_scan();
        bit f, f2;
        int act, dark;
        do_load(16'h12AF, 4'b0000);
        wait_an(4'b0111, f);
        wait_an(4'b1110, f2);
        checks++;
        if (!f || !f2 || seg !== 7'h0E || dp !== 1'b1) begin
            failures++;
            $display("FAIL scan_d0: found=%b seg=%h dp=%b want 0e 1", f && f2, seg, dp);
        end
        act = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an === 4'b1110) act++;
            else break;
        end
        dark = 0;
        for (int i = 0; i < 20 && an === 4'hF; i++) begin
            dark++;
            @(negedge clk);
        end
        checks++;
        if (act !== SD - DC || dark !== DC) begin
            failures++;
            $display("FAIL scan_slot_timing: active=%0d dark=%0d want %0d %0d", act, dark, SD - DC, DC);
        end
        checks++;
        if (an !== 4'b1101 || seg !== 7'h08) begin
            failures++;
            $display("FAIL scan_d1: an=%b seg=%h want 1101 08", an, seg);
        end
        wait_an(4'b1011, f);
        checks++;
        if (!f || seg !== 7'h24) begin
            failures++;
            $display("FAIL scan_d2: found=%b seg=%h want 24", f, seg);
        end
        wait_an(4'b0111, f);
        checks++;
        if (!f || seg !== 7'h79) begin
            failures++;
            $display("FAIL scan_d3: found=%b seg=%h want 79", f, seg);
        end
    endtask

    task automatic test_leading_zeros();
        bit f;
        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0000);
        wait_an(4'b0111, f);
        checks++;
        if (!f || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL lz_d3: found=%b seg=%h dp=%b want 7f 1", f, seg, dp);
        end
        wait_an(4'b1011, f);
        checks++;
        if (!f || seg !== 7'h7F) begin
            failures++;
            $display("FAIL lz_d2: found=%b seg=%h want 7f", f, seg);
        end
        wait_an(4'b1101, f);
        checks++;
        if (!f || seg !== 7'h7F) begin
            failures++;
            $display("FAIL lz_d1: found=%b seg=%h want 7f", f, seg);
        end
        wait_an(4'b1110, f);
        checks++;
        if (!f || seg !== 7'h12) begin
            failures++;
            $display("FAIL lz_d0: found=%b seg=%h want 12", f, seg);
        end

        do_load(16'h0000, 4'b0000);
        wait_an(4'b1110, f);
        checks++;
        if (!f || seg !== 7'h40) begin
            failures++;
            $display("FAIL lz_zero_d0: found=%b seg=%h want 40", f, seg);
        end
        wait_an(4'b1101, f);
        checks++;
        if (!f || seg !== 7'h7F) begin
            failures++;
            $display("FAIL lz_zero_d1: found=%b seg=%h want 7f", f, seg);
        end

        do_load(16'h0005, 4'b0010);
        wait_an(4'b1101, f);
        checks++;
        if (!f || seg !== 7'h40 || dp !== 1'b0) begin
            failures++;
            $display("FAIL lz_dp_d1: found=%b seg=%h dp=%b want 40 0", f, seg, dp);
        end
        wait_an(4'b1011, f);
        checks++;
        if (!f || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL lz_dp_d2: found=%b seg=%h dp=%b want 7f 1", f, seg, dp);
        end
        wait_an(4'b1110, f);
        checks++;
        if (!f || seg !== 7'h12 || dp !== 1'b1) begin
            failures++;
            $display("FAIL lz_dp_d0: found=%b seg=%h dp=%b want 12 1", f, seg, dp);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        bit f0, f1;
        logic [6:0] s0 [8];
        logic [6:0] s1 [8];
        do_load(16'h12AF, 4'b0000);
        blink_mask = 4'b0001;
        repeat (40) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            wait_an(4'b1110, f0);
            s0[k] = f0 ? seg : 7'h55;
            wait_an(4'b1101, f1);
            s1[k] = f1 ? seg : 7'h55;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (s1[k] !== 7'h08) begin
                failures++;
                $display("FAIL blink_d1_steady: frame=%0d seg=%h want 08", k, s1[k]);
            end
            checks++;
            if (s0[k] !== 7'h0E && s0[k] !== 7'h7F) begin
                failures++;
                $display("FAIL blink_d0_code: frame=%0d seg=%h want 0e or 7f", k, s0[k]);
            end
        end
        // With a two-frame half-period, frames two apart are always in opposite phase.
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ((s0[k] === 7'h7F) === (s0[k+2] === 7'h7F)) begin
                failures++;
                $display("FAIL blink_period: frame=%0d seg=%h frame+2 seg=%h want opposite", k, s0[k], s0[k+2]);
            end
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_shadow_enable();
        bit f, f2, off_ok;
        value = 16'h3333;
        repeat (40) @(negedge clk);
        wait_an(4'b1110, f);
        checks++;
        if (!f || seg !== 7'h0E) begin
            failures++;
            $display("FAIL shadow_no_load: found=%b seg=%h want 0e", f, seg);
        end

        wait_an(4'b0111, f);
        wait_an(4'b1110, f2);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++;
        if (!f || !f2 || an !== 4'b1110 || seg !== 7'h0E) begin
            failures++;
            $display("FAIL shadow_mid_slot: an=%b seg=%h want 1110 0e", an, seg);
        end
        wait_an(4'b1101, f);
        checks++;
        if (!f || seg !== 7'h30) begin
            failures++;
            $display("FAIL shadow_next_slot: found=%b seg=%h want 30", f, seg);
        end
        wait_an(4'b1110, f);
        checks++;
        if (!f || seg !== 7'h30) begin
            failures++;
            $display("FAIL shadow_next_frame: found=%b seg=%h want 30", f, seg);
        end

        wait_an(4'b0111, f);
        wait_an(4'b1110, f2);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (!f || !f2 || an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL enable_off: an=%b seg=%h dp=%b want 1111 7f 1", an, seg, dp);
        end
        off_ok = 1'b1;
        repeat (SD - 1) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) off_ok = 1'b0;
        end
        checks++;
        if (!off_ok) begin
            failures++;
            $display("FAIL enable_stays_dark: dark=%b want 1", off_ok);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1101 || seg !== 7'h30) begin
            failures++;
            $display("FAIL enable_scan_kept: an=%b seg=%h want 1101 30", an, seg);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        value      = '0;
        load       = 1'b0;
        enable     = 1'b1;
        blank_lz   = 1'b0;
        dp_in      = '0;
        blink_mask = '0;
        test_reset();
        test_scan();
        test_leading_zeros();
        test_blink();
        test_shadow_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
